// File: rtl/sm_dbg_ctrl.sv
// Run-control and register-dump controller for the schoolRISCV core.
// Optional retired-instruction counter: define SM_DBG_INSTR_CNT_EN.
module sm_dbg_ctrl #(
    parameter bit RESET_RUN = 1'b1,
    parameter int REG_FIRST = 0,
    parameter int REG_LAST  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_arg,
    input  logic [31:0] pc,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    output logic        cpu_en,
    output logic [4:0]  reg_addr,
    input  logic [31:0] reg_data,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic [4:0]  dump_idx,
    output logic        dump_last,
    output logic        halted,
    output logic        bp_hit,
    output logic        cmd_err,
    output logic [31:0] instr_cnt
);
    typedef enum logic [2:0] {
        S_HALT, S_RUN, S_STEP, S_DUMP_RD, S_DUMP_OUT
    } state_t;

    localparam state_t     S_INIT  = RESET_RUN ? S_RUN : S_HALT;
    localparam logic [4:0] L_FIRST = 5'(REG_FIRST);
    localparam logic [4:0] L_LAST  = 5'(REG_LAST);

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic        r_bp_skip;
    logic        r_bp_hit;
    logic        r_cmd_err;
    logic [4:0]  r_reg_addr;
    logic [31:0] r_dump_data;
    logic [4:0]  r_dump_idx;
    logic        w_acc;
    logic        w_halt_acc;
    logic        w_active;
    logic        w_stop;
    logic        w_err;

    assign cmd_ready  = (r_state == S_HALT) || (r_state == S_RUN);
    assign w_acc      = cmd_valid && cmd_ready;
    assign w_halt_acc = w_acc && (r_state == S_HALT);
    assign w_active   = (r_state == S_RUN) || (r_state == S_STEP);
    // A resume parked on the breakpoint must execute it once
    assign w_stop     = bp_en && (pc == bp_addr) && !r_bp_skip;
    assign cpu_en     = w_active && !w_stop;

    assign halted     = (r_state == S_HALT);
    assign dump_valid = (r_state == S_DUMP_OUT);
    assign dump_last  = dump_valid && (r_dump_idx == L_LAST);
    assign dump_data  = r_dump_data;
    assign dump_idx   = r_dump_idx;
    assign reg_addr   = r_reg_addr;
    assign bp_hit     = r_bp_hit;
    assign cmd_err    = r_cmd_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        unique case (r_state)
            S_HALT: begin
                if (w_acc) begin
                    case (cmd_op)
                        OP_RUN:  w_next = S_RUN;
                        OP_STEP: w_next = S_STEP;
                        OP_DUMP: w_next = S_DUMP_RD;
                        default: w_next = S_HALT;
                    endcase
                end
            end
            S_RUN: begin
                if (w_stop) w_next = S_HALT;
                if (w_acc) begin
                    case (cmd_op)
                        OP_HALT: w_next = S_HALT;
                        OP_STEP: w_err  = 1'b1;
                        OP_DUMP: w_err  = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_STEP: begin
                if (w_stop || r_cnt == 16'd1) w_next = S_HALT;
            end
            S_DUMP_RD: w_next = S_DUMP_OUT;
            S_DUMP_OUT: begin
                if (dump_ready) begin
                    if (r_dump_idx == L_LAST) w_next = S_HALT;
                    else                      w_next = S_DUMP_RD;
                end
            end
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bp_skip   <= 1'b0;
            r_bp_hit    <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_reg_addr  <= L_FIRST;
            r_dump_data <= '0;
            r_dump_idx  <= L_FIRST;
        end else begin
            r_bp_hit  <= w_active && w_stop;
            r_cmd_err <= w_err;
            if (w_halt_acc && (cmd_op == OP_RUN || cmd_op == OP_STEP))
                r_bp_skip <= 1'b1;
            else if (cpu_en)
                r_bp_skip <= 1'b0;
            if (w_halt_acc && cmd_op == OP_STEP)
                r_cnt <= (cmd_arg == 16'd0) ? 16'd1 : cmd_arg;
            else if (r_state == S_STEP && cpu_en)
                r_cnt <= r_cnt - 16'd1;
            if (w_halt_acc && cmd_op == OP_DUMP) begin
                r_reg_addr <= L_FIRST;
                r_dump_idx <= L_FIRST;
            end else if (r_state == S_DUMP_OUT && dump_ready
                         && r_dump_idx != L_LAST) begin
                r_reg_addr <= r_reg_addr + 5'd1;
            end
            if (r_state == S_DUMP_RD) begin
                r_dump_data <= reg_data;
                r_dump_idx  <= r_reg_addr;
            end
        end
    end

`ifdef SM_DBG_INSTR_CNT_EN
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_instr_cnt <= '0;
        else if (cpu_en) r_instr_cnt <= r_instr_cnt + 32'd1;
    end

    assign instr_cnt = r_instr_cnt;
`else
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_sm_dbg_ctrl.sv
// Directed bench for sm_dbg_ctrl: table of run-control cycles
// plus breakpoint, dump and reset-during-dump sequences.
module tb_sm_dbg_ctrl;
    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;
`ifdef SM_DBG_INSTR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_arg = 16'd0;
    logic [31:0] pc;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic        cpu_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;
    logic        dump_last;
    logic        halted;
    logic        bp_hit;
    logic        cmd_err;
    logic [31:0] instr_cnt;
    logic        pc_clr = 1'b0;
    logic [31:0] rf [32];

    int n_chk = 0;
    int n_pass = 0;

    sm_dbg_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr),
        .cpu_en(cpu_en), .reg_addr(reg_addr), .reg_data(reg_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_idx(dump_idx),
        .dump_last(dump_last), .halted(halted), .bp_hit(bp_hit),
        .cmd_err(cmd_err), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Core stand-in: PC advances one word per enabled cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pc <= 32'd0;
        else if (pc_clr) pc <= 32'd0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    assign reg_data = rf[reg_addr];

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [15:0] arg;
        logic        ce;
        logic        hl;
        logic        rdy;
        logic        err;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic v, input logic [1:0] op,
                                input logic [15:0] arg, input logic ce,
                                input logic hl, input logic rdy,
                                input logic err);
        vec_t t;
        t.v = v; t.op = op; t.arg = arg;
        t.ce = ce; t.hl = hl; t.rdy = rdy; t.err = err;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        next();
        cmd_valid = 1'b0;
    endtask

    task automatic run_to_bp(input logic [31:0] addr, input logic with_halt);
        logic seen;
        seen = 1'b0;
        pc_clr = 1'b1;
        next();
        pc_clr  = 1'b0;
        bp_en   = 1'b1;
        bp_addr = addr;
        send(OP_RUN, 16'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cpu_en) begin
                seen = 1'b1;
                if (with_halt) begin
                    cmd_valid = 1'b1;
                    cmd_op    = OP_HALT;
                end
                break;
            end
            next();
        end
        chk("bp_stop_seen", {31'd0, seen}, 32'd1);
        chk("bp_stop_pc", pc, addr);
        next();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp_hit_pulse", {31'd0, bp_hit}, 32'd1);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        next();
        @(negedge clk);
        chk("bp_hit_clear", {31'd0, bp_hit}, 32'd0);
        next();
    endtask

    initial begin
        logic        pat [4];
        int          beats;
        int          cpu_bad;
        int          exp_idx;
        int          steps;
        logic [31:0] a0_seen;
        logic        done;

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rf[0] = 32'd0;
        for (int i = 1; i < 32; i++)
            rf[i] = {8'hA5, 8'h3C, 8'(i), 8'(i * 7)};

        tbl[0]  = mk(0, OP_RUN,  16'd0, 1, 0, 1, 0);
        tbl[1]  = mk(1, OP_DUMP, 16'd0, 1, 0, 1, 0);
        tbl[2]  = mk(0, OP_RUN,  16'd0, 1, 0, 1, 1);
        tbl[3]  = mk(0, OP_RUN,  16'd0, 1, 0, 1, 0);
        tbl[4]  = mk(1, OP_HALT, 16'd0, 1, 0, 1, 0);
        tbl[5]  = mk(0, OP_RUN,  16'd0, 0, 1, 1, 0);
        tbl[6]  = mk(1, OP_STEP, 16'd3, 0, 1, 1, 0);
        tbl[7]  = mk(0, OP_RUN,  16'd0, 1, 0, 0, 0);
        tbl[8]  = mk(0, OP_RUN,  16'd0, 1, 0, 0, 0);
        tbl[9]  = mk(0, OP_RUN,  16'd0, 1, 0, 0, 0);
        tbl[10] = mk(0, OP_RUN,  16'd0, 0, 1, 1, 0);
        tbl[11] = mk(1, OP_STEP, 16'd0, 0, 1, 1, 0);
        tbl[12] = mk(0, OP_RUN,  16'd0, 1, 0, 0, 0);
        tbl[13] = mk(0, OP_RUN,  16'd0, 0, 1, 1, 0);
        tbl[14] = mk(1, OP_RUN,  16'd0, 0, 1, 1, 0);
        tbl[15] = mk(0, OP_RUN,  16'd0, 1, 0, 1, 0);
        tbl[16] = mk(1, OP_RUN,  16'd0, 1, 0, 1, 0);
        tbl[17] = mk(1, OP_STEP, 16'd2, 1, 0, 1, 0);
        tbl[18] = mk(0, OP_RUN,  16'd0, 1, 0, 1, 1);

        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
        chk("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
        chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
        chk("rst_instr_cnt", instr_cnt, 32'd0);
        next();
        pc_clr = 1'b1;
        next();
        pc_clr = 1'b0;

        // pc was cleared while running: two retirements happened first
        for (int i = 0; i < 19; i++) begin
            cmd_valid = tbl[i].v;
            cmd_op    = tbl[i].op;
            cmd_arg   = tbl[i].arg;
            @(negedge clk);
            chk($sformatf("t%0d_cpu_en", i), {31'd0, cpu_en}, {31'd0, tbl[i].ce});
            chk($sformatf("t%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].hl});
            chk($sformatf("t%0d_ready", i), {31'd0, cmd_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("t%0d_err", i), {31'd0, cmd_err}, {31'd0, tbl[i].err});
            next();
        end
        cmd_valid = 1'b0;
        chk("tbl_pc", pc, 32'd52);
        chk("tbl_instr_cnt", instr_cnt, CNT_ON ? 32'd15 : 32'd0);
        send(OP_HALT, 16'd0);

        run_to_bp(32'h0C, 1'b0);
        send(OP_RUN, 16'd0);
        @(negedge clk);
        chk("bp_resume_cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("bp_resume_pc", pc, 32'h0C);
        cpu_bad = 0;
        for (int i = 0; i < 5; i++) begin
            next();
            @(negedge clk);
            if (bp_hit || !cpu_en) cpu_bad++;
        end
        chk("bp_no_rehit", cpu_bad, 0);
        next();
        send(OP_HALT, 16'd0);

        run_to_bp(32'h08, 1'b1);
        bp_en = 1'b0;

        send(OP_DUMP, 16'd0);
        beats   = 0;
        cpu_bad = 0;
        exp_idx = 0;
        a0_seen = 32'd0;
        done    = 1'b0;
        for (int c = 0; c < 400; c++) begin
            dump_ready = pat[c % 4];
            @(negedge clk);
            if (cpu_en) cpu_bad++;
            if (dump_valid) begin
                chk("dump_idx", {27'd0, dump_idx}, 32'(exp_idx));
                chk("dump_data", dump_data, rf[exp_idx]);
                chk("dump_last", {31'd0, dump_last}, {31'd0, exp_idx == 31});
                if (exp_idx == 10) a0_seen = dump_data;
                if (dump_ready) begin
                    beats++;
                    exp_idx++;
                    if (exp_idx == 32) begin
                        done = 1'b1;
                        next();
                        break;
                    end
                end
            end
            next();
        end
        dump_ready = 1'b0;
        chk("dump_done", {31'd0, done}, 32'd1);
        chk("dump_beats", beats, 32);
        chk("dump_cpu_frozen", cpu_bad, 0);
        chk("dump_a0", a0_seen, rf[10]);
        @(negedge clk);
        chk("dump_end_halted", {31'd0, halted}, 32'd1);
        chk("dump_end_valid", {31'd0, dump_valid}, 32'd0);
        next();

        send(OP_DUMP, 16'd0);
        done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (dump_valid) begin
                done = 1'b1;
                break;
            end
            next();
        end
        chk("rst_dump_reached", {31'd0, done}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = OP_HALT;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, dump_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst2_cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_instr_cnt", instr_cnt, 32'd0);
        chk("rst2_dump_idx", {27'd0, dump_idx}, 32'd0);
        next();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst2_halt_cmd", {31'd0, halted}, 32'd1);
        next();
        send(OP_STEP, 16'd5);
        steps = 0;
        done  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (halted) begin
                done = 1'b1;
                break;
            end
            if (cpu_en) steps++;
            next();
        end
        chk("step5_done", {31'd0, done}, 32'd1);
        chk("step5_count", steps, 5);
        chk("step5_instr_cnt", instr_cnt, CNT_ON ? 32'd6 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
